// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The fetch PC and instruction word are carried together as one queue entry.
package ifetch_pkg;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

  typedef enum logic [0:0] {
    S_WAIT,
    S_HOLD
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory and decode-side signals of the fetch unit.
// master = fetch unit, slave = memory/decode/branch environment.
interface instruction_fetch_unit_if;

  logic [ifetch_pkg::ADDR_W-1:0]  Address;
  logic [ifetch_pkg::INSTR_W-1:0] Data;
  logic                           Redirect;
  logic [ifetch_pkg::ADDR_W-1:0]  RedirectPC;
  logic                           InstrValid;
  logic                           InstrReady;
  logic [ifetch_pkg::INSTR_W-1:0] Instr;
  logic [ifetch_pkg::ADDR_W-1:0]  InstrPC;
  logic                           FetchFault;

  modport master (
    output Address, InstrValid, Instr, InstrPC, FetchFault,
    input  Data, Redirect, RedirectPC, InstrReady
  );

  modport slave (
    input  Address, InstrValid, Instr, InstrPC, FetchFault,
    output Data, Redirect, RedirectPC, InstrReady
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, instr} entries with a registered head and a flush.
// The head register holds its last value while the queue is empty.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t    mem_q [Depth];
  fetch_entry_t    head_q, head_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] remain;
  logic            valid_q, valid_d;
  logic            do_pop;

  always_comb begin
    do_pop   = pop && valid_q;
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    remain   = count_q - CntW'(do_pop);
    count_d  = remain + CntW'(push);
    valid_d  = (count_d != '0);
    head_d   = head_q;
    // A push into a queue that is (or becomes) empty bypasses storage.
    if (count_d != '0) begin
      head_d = (remain == '0) ? push_entry : mem_q[rd_ptr_d];
    end
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
      head_d   = head_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head  = head_q;
  assign empty = ~valid_q;
  assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch initiator: owns the fetch PC, samples Data RD_WAIT edges after each Address
// change and queues {PC, word} for decode. Optional X/Z trap: IFETCH_UNDEF_TRAP_EN.
module instruction_fetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned RD_WAIT    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                      CLK,
  input logic                      resetl,
  instruction_fetch_unit_if.master bus
);

  localparam int unsigned WaitW = $clog2(RD_WAIT) + 1;
  localparam logic [WaitW-1:0] WaitReload = WaitW'(RD_WAIT - 1);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fault_q, fault_d;
  logic              push, pop, space, sample_ok, try_sample;
  logic              fifo_empty;
  logic [CntW-1:0]   fifo_count;
  fetch_entry_t      sample, head;

  assign pop   = bus.InstrReady & ~fifo_empty;
  assign space = (fifo_count < CntW'(FIFO_DEPTH)) | pop;

`ifdef IFETCH_UNDEF_TRAP_EN
  assign sample_ok = !$isunknown(bus.Data);
`else
  assign sample_ok = 1'b1;
`endif

  assign sample.pc    = addr_q;
  assign sample.instr = bus.Data;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    fault_d    = fault_q;
    push       = 1'b0;
    try_sample = 1'b0;
    if (bus.Redirect) begin
      // Pending sample is dropped; the queue is flushed alongside.
      state_d    = S_WAIT;
      wait_cnt_d = WaitReload;
      addr_d     = align_pc(bus.RedirectPC);
      fault_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          if (wait_cnt_q != '0) begin
            wait_cnt_d = wait_cnt_q - WaitW'(1);
          end else begin
            try_sample = 1'b1;
          end
        end
        S_HOLD:  try_sample = !fault_q;
        default: state_d = S_WAIT;
      endcase
      if (try_sample) begin
        if (!sample_ok) begin
          fault_d = 1'b1;
          state_d = S_HOLD;
        end else if (space) begin
          push       = 1'b1;
          addr_d     = addr_q + PC_STEP;
          wait_cnt_d = WaitReload;
          state_d    = S_WAIT;
        end else begin
          state_d = S_HOLD;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q    <= S_WAIT;
      wait_cnt_q <= WaitReload;
      addr_q     <= RESET_PC;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      fault_q    <= fault_d;
    end
  end

  fetch_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (resetl),
    .push       (push),
    .push_entry (sample),
    .pop        (pop),
    .flush      (bus.Redirect),
    .head       (head),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign bus.Address    = addr_q;
  assign bus.InstrValid = ~fifo_empty;
  assign bus.Instr      = head.instr;
  assign bus.InstrPC    = head.pc;
  assign bus.FetchFault = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a main instance at RESET_PC=0 and a
// second instance at the top of the address space for the wrap case.
module tb_instruction_fetch_unit;
  import ifetch_pkg::*;

  logic CLK = 1'b0;
  logic resetl;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   got;
  logic seen;
  logic [31:0] t1_exp [3] = '{32'hF84003E9, 32'hF84083EA, 32'hF84103EB};

  always #5 CLK = ~CLK;

  instruction_fetch_unit_if bus ();
  instruction_fetch_unit_if wbus ();

  instruction_fetch_unit #(
    .RESET_PC   (64'h0),
    .RD_WAIT    (2),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK    (CLK),
    .resetl (resetl),
    .bus    (bus)
  );

  instruction_fetch_unit #(
    .RESET_PC   (64'hFFFF_FFFF_FFFF_FFFC),
    .RD_WAIT    (2),
    .FIFO_DEPTH (4)
  ) dut_wrap (
    .CLK    (CLK),
    .resetl (resetl),
    .bus    (wbus)
  );

  // Program image at 0x000..0x05C, undefined elsewhere.
  function automatic logic [31:0] prog_word(input logic [63:0] a);
    logic [31:0] w;
    if (a >= 64'h60) return 32'hxxxx_xxxx;
    case (a[6:2])
      5'd0:    w = 32'hF84003E9;
      5'd1:    w = 32'hF84083EA;
      5'd2:    w = 32'hF84103EB;
      5'd11:   w = 32'hF80203ED;
      default: w = 32'h1300_0000 + 32'(a[6:0]);
    endcase
    return w;
  endfunction

  assign bus.Data  = prog_word(bus.Address);
  assign wbus.Data = wbus.Address[31:0] ^ 32'h5A5A_5A5A;

  task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    resetl         = 1'b0;
    bus.Redirect   = 1'b0;
    bus.RedirectPC = 64'h0;
    bus.InstrReady = 1'b1;
    repeat (2) tick();
    resetl = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetl          = 1'b0;
    bus.Redirect    = 1'b0;
    bus.RedirectPC  = 64'h0;
    bus.InstrReady  = 1'b1;
    wbus.Redirect   = 1'b0;
    wbus.RedirectPC = 64'h0;
    wbus.InstrReady = 1'b1;
    repeat (2) tick();

    // Reset state
    check_eq("rst_addr", bus.Address, 64'h0);
    check_eq("rst_valid", 64'(bus.InstrValid), 64'h0);
    check_eq("rst_instr", 64'(bus.Instr), 64'h0);
    check_eq("rst_pc", bus.InstrPC, 64'h0);
    check_eq("rst_fault", 64'(bus.FetchFault), 64'h0);
    check_eq("rst_wrap_addr", wbus.Address, 64'hFFFF_FFFF_FFFF_FFFC);
    resetl = 1'b1;

    // 1: streaming, one valid every two cycles
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_eq($sformatf("t1_valid_%0d", i), 64'(bus.InstrValid), 64'(i % 2 == 0));
      if (i % 2 == 0) begin
        check_eq($sformatf("t1_pc_%0d", i), bus.InstrPC, 64'((i / 2 - 1) * 4));
        check_eq($sformatf("t1_instr_%0d", i), 64'(bus.Instr), 64'(t1_exp[i/2-1]));
      end
    end

    // 2: decode stall fills the queue, then drains in order
    do_reset();
    bus.InstrReady = 1'b0;
    repeat (20) tick();
    check_eq("t2_addr_hold", bus.Address, 64'h10);
    check_eq("t2_valid", 64'(bus.InstrValid), 64'h1);
    check_eq("t2_head_pc", bus.InstrPC, 64'h0);
    bus.InstrReady = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      if (bus.InstrValid) begin
        check_eq($sformatf("t2_pc_%0d", got), bus.InstrPC, 64'(got * 4));
        check_eq($sformatf("t2_instr_%0d", got), 64'(bus.Instr), 64'(prog_word(64'(got * 4))));
        got++;
      end
      tick();
    end
    check_eq("t2_count", 64'(got), 64'd5);

    // 3: redirect on a full queue with a same-cycle pop
    do_reset();
    bus.InstrReady = 1'b0;
    repeat (12) tick();
    check_eq("t3_full_valid", 64'(bus.InstrValid), 64'h1);
    check_eq("t3_full_head", bus.InstrPC, 64'h0);
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 64'h2E;
    bus.InstrReady = 1'b1;
    tick();
    bus.Redirect   = 1'b0;
    bus.InstrReady = 1'b0;
    check_eq("t3_flush_valid", 64'(bus.InstrValid), 64'h0);
    check_eq("t3_redir_addr", bus.Address, 64'h2C);
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      tick();
      if (bus.InstrValid) seen = 1'b1;
    end
    check_eq("t3_seen", 64'(seen), 64'h1);
    check_eq("t3_pc", bus.InstrPC, 64'h2C);
    check_eq("t3_instr", 64'(bus.Instr), 64'hF80203ED);

    // 4: asynchronous reset mid-operation
    do_reset();
    bus.InstrReady = 1'b0;
    repeat (3) tick();
    check_eq("t4_pre_valid", 64'(bus.InstrValid), 64'h1);
    check_eq("t4_pre_addr", bus.Address, 64'h4);
    #2 resetl = 1'b0;
    #1;
    check_eq("t4_async_valid", 64'(bus.InstrValid), 64'h0);
    check_eq("t4_async_addr", bus.Address, 64'h0);
    tick();
    resetl = 1'b1;
    tick();
    check_eq("t4_rel_valid", 64'(bus.InstrValid), 64'h0);
    tick();
    check_eq("t4_first_valid", 64'(bus.InstrValid), 64'h1);
    check_eq("t4_first_pc", bus.InstrPC, 64'h0);
    check_eq("t4_first_instr", 64'(bus.Instr), 64'hF84003E9);

    // 5: address wrap at the top of the address space
    resetl = 1'b0;
    tick();
    check_eq("t5_rst_addr", wbus.Address, 64'hFFFF_FFFF_FFFF_FFFC);
    resetl = 1'b1;
    tick();
    check_eq("t5_e1_valid", 64'(wbus.InstrValid), 64'h0);
    tick();
    check_eq("t5_e2_valid", 64'(wbus.InstrValid), 64'h1);
    check_eq("t5_e2_pc", wbus.InstrPC, 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("t5_e2_addr", wbus.Address, 64'h0);
    repeat (2) tick();
    check_eq("t5_e4_pc", wbus.InstrPC, 64'h0);
    check_eq("t5_e4_addr", wbus.Address, 64'h4);

    // 6: redirect into undefined memory
    bus.InstrReady = 1'b1;
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 64'h100;
    tick();
    bus.Redirect = 1'b0;
    check_eq("t6_addr", bus.Address, 64'h100);
    repeat (2) tick();
`ifdef IFETCH_UNDEF_TRAP_EN
    check_eq("t6_fault", 64'(bus.FetchFault), 64'h1);
    check_eq("t6_valid", 64'(bus.InstrValid), 64'h0);
    repeat (4) tick();
    check_eq("t6_addr_frozen", bus.Address, 64'h100);
`else
    check_eq("t6_valid", 64'(bus.InstrValid), 64'h1);
    check_eq("t6_pc", bus.InstrPC, 64'h100);
    check_eq("t6_fault", 64'(bus.FetchFault), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
